// File: rtl/demux3_route.sv
// Registered 1-to-2 routing stage: a producer value plus a 3-bit choice is steered
// into one of two single-entry holding slots; codes other than 1 and 2 are dropped and counted.
//
// slot state | meaning
// -----------|----------------------------------------------
// EMPTY      | holding register has no data (outN_valid = 0)
// FULL       | holding register owns data   (outN_valid = 1)
module demux3_route #(
  parameter int WIDTH  = 32,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [WIDTH-1:0]  in,
  input  logic [2:0]        choice,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out1,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [WIDTH-1:0]  out2,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  slot_state_t      slot1_q, slot1_d;
  slot_state_t      slot2_q, slot2_d;
  logic [WIDTH-1:0] data1_q, data2_q;
  logic             sel1, sel2, sel_drop;
  logic             free1, free2;
  logic             accept;
  logic             load1, load2;
  logic             drop_inc;

  always_comb begin
    sel1     = (choice == 3'd1);
    sel2     = (choice == 3'd2);
    sel_drop = !sel1 && !sel2;
    free1    = (slot1_q == EMPTY) || out1_ready;
    free2    = (slot2_q == EMPTY) || out2_ready;

    in_ready = 1'b0;
    if (ena) begin
      if (sel1)      in_ready = free1;
      else if (sel2) in_ready = free2;
      else           in_ready = 1'b1;
    end

    accept   = in_valid && in_ready;
    load1    = accept && sel1;
    load2    = accept && sel2;
    drop_inc = accept && sel_drop && (drop_cnt != DROP_MAX);
  end

  // Drain first, then a same-cycle load overrides it so a draining slot stays FULL.
  always_comb begin
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    if (slot1_q == FULL && out1_ready) slot1_d = EMPTY;
    if (load1)                         slot1_d = FULL;
    if (slot2_q == FULL && out2_ready) slot2_d = EMPTY;
    if (load2)                         slot2_d = FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot1_q <= EMPTY;
      slot2_q <= EMPTY;
    end else begin
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
    end
  end

  // Holding data is only written on load; it keeps its last value while EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      if (load1) data1_q <= in;
      if (load2) data2_q <= in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      if (drop_inc)                drop_cnt <= drop_cnt + 1'b1;
      if (accept && sel_drop)      drop_err <= 1'b1;
    end
  end

  assign out1       = data1_q;
  assign out2       = data2_q;
  assign out1_valid = (slot1_q == FULL);
  assign out2_valid = (slot2_q == FULL);

endmodule

// File: tb/tb_demux3_route.sv
// Directed and scoreboard-driven bench for demux3_route.
// Inputs change 1 ns after the rising edge; outputs are sampled in the same window.
module tb_demux3_route;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] din;
  logic [2:0]  choice;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1, out2;
  logic        out1_valid, out2_valid;
  logic        out1_ready, out2_ready;
  logic [7:0]  drop_cnt;
  logic        drop_err;

  int errors = 0;
  int checks = 0;

  demux3_route #(.WIDTH(32), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in(din), .choice(choice),
    .in_valid(in_valid), .in_ready(in_ready),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2(out2), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .drop_cnt(drop_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0; ena = 1'b0; choice = 3'd0; din = '0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b/%b exp 0/0", out1_valid, out2_valid); end
    ena = 1'b1; in_valid = 1'b1; choice = 3'd1; din = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    checks++; if (out1_valid !== 1'b1 || out1 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL prefill: got %b %h exp 1 deadbeef", out1_valid, out1); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out1_valid !== 1'b0 || out1 !== 32'h0) begin errors++;
      $display("FAIL async_reset_slot: got %b %h exp 0 00000000", out1_valid, out1); end
    checks++; if (drop_cnt !== 8'd0 || drop_err !== 1'b0) begin errors++;
      $display("FAIL async_reset_drop: got %0d %b exp 0 0", drop_cnt, drop_err); end
    // No accept may land while reset is held, even though in_ready is asserted
    @(posedge clk); #1;
    in_valid = 1'b1; choice = 3'd2; din = 32'h5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL ready_in_reset: got %b exp 1", in_ready); end
    tick();
    checks++; if (out2_valid !== 1'b0) begin errors++;
      $display("FAIL accept_in_reset: got %b exp 0", out2_valid); end
    rst = 1'b0;
    tick();
    checks++; if (out2_valid !== 1'b1 || out2 !== 32'h5) begin errors++;
      $display("FAIL first_after_reset: got %b %h exp 1 00000005", out2_valid, out2); end
    in_valid = 1'b0; out2_ready = 1'b1;
    tick();
    checks++; if (out2_valid !== 1'b0) begin errors++;
      $display("FAIL drain_after_reset: got %b exp 0", out2_valid); end
  endtask

  task automatic test_basic;
    do_reset();
    ena = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    in_valid = 1'b1; choice = 3'd1; din = 32'h11111111;
    tick();
    checks++; if (out1_valid !== 1'b1 || out1 !== 32'h11111111) begin errors++;
      $display("FAIL basic_out1: got %b %h exp 1 11111111", out1_valid, out1); end
    choice = 3'd2; din = 32'h22222222;
    tick();
    checks++; if (out2_valid !== 1'b1 || out2 !== 32'h22222222) begin errors++;
      $display("FAIL basic_out2: got %b %h exp 1 22222222", out2_valid, out2); end
    checks++; if (out1_valid !== 1'b0 || out1 !== 32'h11111111) begin errors++;
      $display("FAIL basic_out1_drained: got %b %h exp 0 11111111", out1_valid, out1); end
    in_valid = 1'b0;
    tick();
    checks++; if (out2_valid !== 1'b0 || drop_cnt !== 8'd0 || drop_err !== 1'b0) begin errors++;
      $display("FAIL basic_idle: got %b %0d %b exp 0 0 0", out2_valid, drop_cnt, drop_err); end
  endtask

  task automatic test_backpressure;
    do_reset();
    ena = 1'b1; out1_ready = 1'b0; out2_ready = 1'b1;
    in_valid = 1'b1; choice = 3'd1; din = 32'h1;
    tick();
    din = 32'h2;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_stall_ready: got %b exp 0", in_ready); end
    tick();
    checks++; if (out1_valid !== 1'b1 || out1 !== 32'h1) begin errors++;
      $display("FAIL bp_hold: got %b %h exp 1 00000001", out1_valid, out1); end
    out1_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
    tick();
    checks++; if (out1_valid !== 1'b1 || out1 !== 32'h2) begin errors++;
      $display("FAIL bp_passthrough: got %b %h exp 1 00000002", out1_valid, out1); end
    out1_ready = 1'b0; out2_ready = 1'b0; choice = 3'd2; din = 32'h3;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_other_slot_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out2_valid !== 1'b1 || out2 !== 32'h3 || out1_valid !== 1'b1 || out1 !== 32'h2) begin errors++;
      $display("FAIL bp_independent: got %b %h %b %h exp 1 00000003 1 00000002",
               out2_valid, out2, out1_valid, out1); end
  endtask

  task automatic test_drop;
    int codes [6] = '{0, 3, 7, 4, 5, 6};
    do_reset();
    ena = 1'b1; in_valid = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      choice = codes[i % 6][2:0];
      din = i;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL drop_ready[%0d]: got %b exp 1", i, in_ready); end
      if (i == 254) begin
        checks++; if (drop_cnt !== 8'd254) begin errors++;
          $display("FAIL drop_cnt_254: got %0d exp 254", drop_cnt); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255 || drop_err !== 1'b1) begin errors++;
      $display("FAIL drop_saturate: got %0d %b exp 255 1", drop_cnt, drop_err); end
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || out1 !== 32'h0 || out2 !== 32'h0) begin errors++;
      $display("FAIL drop_no_slot: got %b %b %h %h exp 0 0 0 0", out1_valid, out2_valid, out1, out2); end
    choice = 3'd0;
    tick();
    checks++; if (drop_cnt !== 8'd255) begin errors++;
      $display("FAIL drop_idle_nocount: got %0d exp 255", drop_cnt); end
  endtask

  task automatic test_enable;
    do_reset();
    ena = 1'b1; out1_ready = 1'b0; in_valid = 1'b1; choice = 3'd1; din = 32'hAA;
    tick();
    ena = 1'b0; choice = 3'd2; din = 32'hBB; out1_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL ena_ready: got %b exp 0", in_ready); end
    tick();
    checks++; if (out2_valid !== 1'b0 || out1_valid !== 1'b0 || out1 !== 32'hAA) begin errors++;
      $display("FAIL ena_gate: got %b %b %h exp 0 0 000000aa", out2_valid, out1_valid, out1); end
    choice = 3'd3;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL ena_drop_ready: got %b exp 0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd0 || drop_err !== 1'b0) begin errors++;
      $display("FAIL ena_drop_nocount: got %0d %b exp 0 0", drop_cnt, drop_err); end
  endtask

  task automatic test_soak;
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [7:0]  m_drop;
    logic        m_err;
    logic        exp_ready;
    logic        acc;
    do_reset();
    m_drop = 8'd0; m_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (out1_valid !== (q1.size() != 0)) begin errors++;
        $display("FAIL soak_v1[%0d]: got %b exp %b", c, out1_valid, q1.size() != 0); end
      if (q1.size() != 0) begin
        checks++; if (out1 !== q1[0]) begin errors++;
          $display("FAIL soak_d1[%0d]: got %h exp %h", c, out1, q1[0]); end
      end
      checks++; if (out2_valid !== (q2.size() != 0)) begin errors++;
        $display("FAIL soak_v2[%0d]: got %b exp %b", c, out2_valid, q2.size() != 0); end
      if (q2.size() != 0) begin
        checks++; if (out2 !== q2[0]) begin errors++;
          $display("FAIL soak_d2[%0d]: got %h exp %h", c, out2, q2[0]); end
      end
      checks++; if (drop_cnt !== m_drop || drop_err !== m_err) begin errors++;
        $display("FAIL soak_drop[%0d]: got %0d %b exp %0d %b", c, drop_cnt, drop_err, m_drop, m_err); end

      ena        = ($urandom_range(0, 9) != 0);
      in_valid   = $urandom_range(0, 1);
      choice     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
      din        = $urandom;
      out1_ready = $urandom_range(0, 1);
      out2_ready = $urandom_range(0, 1);
      #1;
      if (!ena)               exp_ready = 1'b0;
      else if (choice == 3'd1) exp_ready = (q1.size() == 0) || out1_ready;
      else if (choice == 3'd2) exp_ready = (q2.size() == 0) || out2_ready;
      else                     exp_ready = 1'b1;
      checks++; if (in_ready !== exp_ready) begin errors++;
        $display("FAIL soak_ready[%0d]: got %b exp %b", c, in_ready, exp_ready); end

      acc = in_valid && exp_ready;
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
      if (q2.size() != 0 && out2_ready) void'(q2.pop_front());
      if (acc && choice == 3'd1) q1.push_back(din);
      else if (acc && choice == 3'd2) q2.push_back(din);
      else if (acc) begin
        m_err = 1'b1;
        if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (drop_cnt !== m_drop) begin errors++;
      $display("FAIL soak_final_drop: got %0d exp %0d", drop_cnt, m_drop); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_enable();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
